// File: rtl/video_mono_stage.sv
// Three-stage video post-processor: 6-bit RGB to 8-bit RGB with optional monochrome tint.
// The tint mode is latched only on a VSync rising edge so a frame never changes tint mid-way.
module video_mono_stage #(
    parameter int LAT = 3,
    parameter int WR  = 54,
    parameter int WG  = 183,
    parameter int WB  = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_in,
    input  logic [5:0] r_in,
    input  logic [5:0] g_in,
    input  logic [5:0] b_in,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       hb_in,
    input  logic       vb_in,
    input  logic [1:0] mode_in,
    output logic       ce_pix,
    output logic [7:0] r_out,
    output logic [7:0] g_out,
    output logic [7:0] b_out,
    output logic       hs_out,
    output logic       vs_out,
    output logic       hb_out,
    output logic       vb_out,
    output logic [1:0] mode_active
);
    localparam logic [7:0] WR8 = 8'(WR);
    localparam logic [7:0] WG8 = 8'(WG);
    localparam logic [7:0] WB8 = 8'(WB);

    function automatic logic [7:0] expand(input logic [5:0] x);
        return {x, x[5:4]};
    endfunction

    logic [5:0]     r1, g1, b1, r2, g2, b2, y2;
    logic           hs1, vs1, hb1, vb1, hs2, vs2, hb2, vb2;
    logic           vs_d;
    logic [LAT-1:0] ce_pipe;
    logic [13:0]    pr, pg, pb;
    logic [15:0]    sum;
    logic [5:0]     sel_r, sel_g, sel_b;

    always_comb begin
        pr  = 14'(WR8) * 14'(r1);
        pg  = 14'(WG8) * 14'(g1);
        pb  = 14'(WB8) * 14'(b1);
        sum = 16'(pr) + 16'(pg) + 16'(pb);
    end

    // Tint selection uses the stage-2 copies and the currently latched mode.
    always_comb begin
        sel_r = r2;
        sel_g = g2;
        sel_b = b2;
        case (mode_active)
            2'b01: begin sel_r = '0; sel_g = y2;      sel_b = '0; end
            2'b10: begin sel_r = y2; sel_g = y2 >> 1; sel_b = '0; end
            2'b11: begin sel_r = y2; sel_g = y2;      sel_b = y2; end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {r1, g1, b1, r2, g2, b2, y2} <= '0;
            {hs1, vs1, hs2, vs2} <= '0;
            {hb1, vb1, hb2, vb2} <= '1;
            vs_d        <= 1'b0;
            ce_pipe     <= '0;
            r_out       <= '0;
            g_out       <= '0;
            b_out       <= '0;
            hs_out      <= 1'b0;
            vs_out      <= 1'b0;
            hb_out      <= 1'b1;
            vb_out      <= 1'b1;
            mode_active <= 2'b00;
        end else begin
            r1  <= r_in;  g1  <= g_in;  b1  <= b_in;
            hs1 <= hs_in; vs1 <= vs_in; hb1 <= hb_in; vb1 <= vb_in;
            vs_d <= vs_in;

            y2  <= 6'(sum >> 8);
            r2  <= r1;  g2  <= g1;  b2  <= b1;
            hs2 <= hs1; vs2 <= vs1; hb2 <= hb1; vb2 <= vb1;

            ce_pipe <= {ce_pipe[LAT-2:0], ce_in};
            r_out   <= (hb2 || vb2) ? 8'h00 : expand(sel_r);
            g_out   <= (hb2 || vb2) ? 8'h00 : expand(sel_g);
            b_out   <= (hb2 || vb2) ? 8'h00 : expand(sel_b);
            hs_out  <= hs2;
            vs_out  <= vs2;
            hb_out  <= hb2;
            vb_out  <= vb2;

            if (vs_in && !vs_d)
                mode_active <= mode_in;
        end
    end

    assign ce_pix = ce_pipe[LAT-1];
endmodule
